// File: rtl/nibble_serial_adder_12.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_12
//
// Purpose:
//    Multi-cycle adder for the 12-bit datapath. One NIB-bit slice is added per
//    clock with a carry-lookahead slice, and the carry ripples between slices
//    through a register. The control FSM drives it with a start/done handshake.
//    Operation: IDLE (sample start) -> RUN (NSLICE cycles) -> DONE (1 cycle).
//
// Parameters:
//    WIDTH  operand/result width, a multiple of NIB (default 12)
//    NIB    slice width added per cycle (default 4)
//
// Ports:
//    clk    in   1      rising-edge clock
//    rst_n  in   1      asynchronous active-low reset
//    start  in   1      request, sampled only while idle
//    a      in   WIDTH  addend A, captured with start
//    b      in   WIDTH  addend B, captured with start
//    cin    in   1      carry into bit 0, captured with start
//    busy   out  1      high while an operation is in progress (RUN or DONE)
//    done   out  1      one-cycle pulse, result valid
//    sum    out  WIDTH  registered result, held until the next DONE
//    cout   out  1      carry out of the MSB (unsigned overflow)
//    ovf    out  1      signed overflow (carry into MSB xor carry out of MSB)
// ---------------------------------------------------------------------------
module nibble_serial_adder_12 #(
   parameter int WIDTH = 12,
   parameter int NIB   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSLICE = WIDTH / NIB;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Carry-lookahead slice. Returns {c[NIB], c[NIB-1], sum[NIB-1:0]}.
   // Each carry is built in flattened sum-of-products form from G/P and the
   // slice carry-in, so no carry depends on the previous bit's carry.
   function automatic logic [NIB+1:0] cla_slice(
      input logic [NIB-1:0] x,
      input logic [NIB-1:0] y,
      input logic           ci
   );
      logic [NIB-1:0] g;
      logic [NIB-1:0] p;
      logic [NIB-1:0] s;
      logic [NIB:0]   c;
      logic           term;
      logic           pp;
      g    = x & y;
      p    = x ^ y;
      c    = {(NIB+1){1'b0}};
      c[0] = ci;
      for (int i = 0; i < NIB; i++) begin
         term = 1'b0;
         pp   = 1'b1;
         // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci
         for (int j = i; j >= 0; j--) begin
            term = term | (g[j] & pp);
            pp   = pp & p[j];
         end
         c[i+1] = term | (pp & ci);
      end
      s = p ^ c[NIB-1:0];
      return {c[NIB], c[NIB-1], s};
   endfunction

   state_t           state_r;
   state_t           next_state_s;
   logic [IW-1:0]    idx_r;
   logic             carry_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] acc_s;
   logic [NIB+1:0]   slice_s;
   logic             last_s;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic and the combinational slice addition for the current index.
   always_comb begin
      next_state_s = state_r;
      last_s       = (idx_r == IW'(NSLICE - 1));
      slice_s      = cla_slice(a_r[int'(idx_r)*NIB +: NIB],
                               b_r[int'(idx_r)*NIB +: NIB],
                               carry_r);
      acc_s        = acc_r;
      acc_s[int'(idx_r)*NIB +: NIB] = slice_s[NIB-1:0];
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = RUN;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = RUN;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Operand capture, per-slice accumulation and result/flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r   <= {IW{1'b0}};
         carry_r <= 1'b0;
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         acc_r   <= {WIDTH{1'b0}};
         sum     <= {WIDTH{1'b0}};
         cout    <= 1'b0;
         ovf     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         // busy/done are registered copies of the state being entered
         busy <= (next_state_s != IDLE);
         done <= (next_state_s == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  carry_r <= cin;
                  idx_r   <= {IW{1'b0}};
                  acc_r   <= {WIDTH{1'b0}};
               end else begin
                  carry_r <= carry_r;
               end
            end
            RUN: begin
               acc_r   <= acc_s;
               carry_r <= slice_s[NIB+1];
               if (last_s) begin
                  // Publish the full result only once the top slice is in.
                  idx_r <= {IW{1'b0}};
                  sum   <= acc_s;
                  cout  <= slice_s[NIB+1];
                  ovf   <= slice_s[NIB+1] ^ slice_s[NIB];
               end else begin
                  idx_r <= idx_r + IW'(1);
               end
            end
            DONE: begin
               carry_r <= carry_r;
            end
            default: begin
               carry_r <= carry_r;
            end
         endcase
      end
   end

endmodule
